// File: rtl/calc_rr_arbiter.sv
// Round-robin front end sharing one pipelined c = 12*a + 5*b datapath among NUM_REQ requesters.
// Each requester has one outstanding operation and a held result with a valid/ready handshake.
module calc_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  input  logic [4*NUM_REQ-1:0]   req_a,
  input  logic [4*NUM_REQ-1:0]   req_b,
  output logic [NUM_REQ-1:0]     req_ready,
  output logic [NUM_REQ-1:0]     rsp_valid,
  input  logic [NUM_REQ-1:0]     rsp_ready,
  output logic [9*NUM_REQ-1:0]   rsp_c
);

  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] eligible;
  logic [NUM_REQ-1:0] grant;
  logic [IDW-1:0]     grant_id;
  logic               grant_any;
  logic [IDW-1:0]     ptr;
  int                 sel_idx;

  logic               s1_valid;
  logic [3:0]         s1_a;
  logic [3:0]         s1_b;
  logic [IDW-1:0]     s1_id;
  logic               s2_valid;
  logic [8:0]         s2_c;
  logic [IDW-1:0]     s2_id;
  logic [8:0]         a9;
  logic [8:0]         b9;
  logic [8:0]         s1_c;

  assign eligible = req_valid & ~busy;

  // First eligible requester at or after ptr, wrapping around.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    sel_idx   = 0;
    for (int off = 0; off < NUM_REQ; off++) begin
      sel_idx = (int'(ptr) + off) % NUM_REQ;
      if (!grant_any && eligible[sel_idx]) begin
        grant[sel_idx] = 1'b1;
        grant_id       = IDW'(sel_idx);
        grant_any      = 1'b1;
      end
    end
  end

  assign req_ready = rst_n ? grant : '0;

  assign a9   = {5'b0, s1_a};
  assign b9   = {5'b0, s1_b};
  assign s1_c = (a9 << 3) + (a9 << 2) + (b9 << 2) + b9;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (grant_any) begin
      ptr <= (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  // Busy spans accept to response handshake, so a requester never has two ops in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i])
          busy[i] <= 1'b1;
        else if (rsp_valid[i] && rsp_ready[i])
          busy[i] <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      s2_c     <= '0;
      s2_id    <= '0;
    end else begin
      s1_valid <= grant_any;
      if (grant_any) begin
        s1_a  <= req_a[4*grant_id +: 4];
        s1_b  <= req_b[4*grant_id +: 4];
        s1_id <= grant_id;
      end
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_c  <= s1_c;
        s2_id <= s1_id;
      end
    end
  end

  // Results are held until consumed; rsp_c keeps its last value after the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= '0;
      rsp_c     <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (s2_valid && s2_id == IDW'(i)) begin
          rsp_valid[i]     <= 1'b1;
          rsp_c[9*i +: 9]  <= s2_c;
        end else if (rsp_valid[i] && rsp_ready[i]) begin
          rsp_valid[i]     <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_calc_rr_arbiter.sv
// Directed bench for calc_rr_arbiter: accepted requests push hand-computed results into a
// scoreboard that a separate monitor checks against the held responses.
module tb_calc_rr_arbiter;

  localparam int N = 4;

  logic           clk;
  logic           rst_n;
  logic [N-1:0]   req_valid;
  logic [4*N-1:0] req_a;
  logic [4*N-1:0] req_b;
  logic [N-1:0]   req_ready;
  logic [N-1:0]   rsp_valid;
  logic [N-1:0]   rsp_ready;
  logic [9*N-1:0] rsp_c;

  typedef struct {
    int         id;
    logic [8:0] c;
    int         acc;
  } entry_t;

  entry_t     sb[$];
  logic [8:0] exp_tab[N];
  logic [8:0] last_c[N];
  logic [N-1:0] busy_m;
  logic [N-1:0] prev_rv;
  int cyc;
  int checks;
  int fails;

  calc_rr_arbiter #(.NUM_REQ(N), .IDW(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_c(rsp_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, required %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic int findEntry(input int id);
    for (int k = 0; k < sb.size(); k++)
      if (sb[k].id == id) return k;
    return -1;
  endfunction

  // Monitor: legal grants, latency on rising rsp_valid, held value, retained value, pops on handshake.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      busy_m  = '0;
      prev_rv = '0;
      for (int i = 0; i < N; i++) last_c[i] = 9'd0;
      checkOutput("reset rsp_valid", 32'(rsp_valid), 32'd0);
      checkOutput("reset req_ready", 32'(req_ready), 32'd0);
    end else begin
      checkOutput("grant legal",
                  32'(((req_ready & ~(req_valid & ~busy_m)) == '0) && $onehot0(req_ready)), 32'd1);
      for (int i = 0; i < N; i++) begin
        int k;
        k = findEntry(i);
        if (rsp_valid[i]) begin
          if (k < 0) begin
            checkOutput($sformatf("unexpected rsp_valid[%0d]", i), 32'd1, 32'd0);
          end else begin
            if (!prev_rv[i])
              checkOutput($sformatf("latency[%0d]", i), 32'(cyc - sb[k].acc), 32'd3);
            checkOutput($sformatf("rsp_c[%0d]", i), 32'(rsp_c[9*i +: 9]), 32'(sb[k].c));
            if (rsp_ready[i]) begin
              last_c[i] = sb[k].c;
              sb.delete(k);
              busy_m[i] = 1'b0;
            end
          end
        end else begin
          checkOutput($sformatf("rsp_c retained[%0d]", i), 32'(rsp_c[9*i +: 9]), 32'(last_c[i]));
        end
        if (req_valid[i] && req_ready[i]) begin
          sb.push_back('{id: i, c: exp_tab[i], acc: cyc});
          busy_m[i] = 1'b1;
        end
      end
      prev_rv = rsp_valid;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int i, input logic [3:0] a, input logic [3:0] b,
                               input logic [8:0] c);
    req_a[4*i +: 4] = a;
    req_b[4*i +: 4] = b;
    exp_tab[i]      = c;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic waitRsp(input int i, input int max_cyc);
    logic got;
    got = 1'b0;
    for (int n = 0; n < max_cyc && !got; n++) begin
      @(negedge clk);
      if (rsp_valid[i]) got = 1'b1;
    end
    checkOutput($sformatf("rsp arrives[%0d]", i), 32'(got), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int others;
    logic [N-1:0] seq [8];
    cyc = 0; checks = 0; fails = 0;
    req_valid = '0; rsp_ready = '0; req_a = '0; req_b = '0;
    for (int i = 0; i < N; i++) exp_tab[i] = 9'd0;
    doReset();

    // Single request on requester 2, held response, then consume.
    applyStimulus(2, 4'd3, 4'd4, 9'd56);
    req_valid = 4'b0100;
    @(negedge clk);
    checkOutput("single grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    waitRsp(2, 6);
    repeat (3) @(negedge clk);
    checkOutput("held rsp_valid", 32'(rsp_valid), 32'b0100);
    tick();
    rsp_ready = 4'b0100;
    tick();
    rsp_ready = '0;
    @(negedge clk);
    checkOutput("rsp_valid dropped", 32'(rsp_valid), 32'd0);

    // Max and zero operands on requester 0.
    rsp_ready = 4'b1111;
    tick();
    applyStimulus(0, 4'd15, 4'd15, 9'd255);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (6) tick();
    applyStimulus(0, 4'd0, 4'd0, 9'd0);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (6) tick();

    // All requesters continuously valid from reset.
    doReset();
    rsp_ready = 4'b1111;
    applyStimulus(0, 4'd1, 4'd2, 9'd22);
    applyStimulus(1, 4'd2, 4'd1, 9'd29);
    applyStimulus(2, 4'd5, 4'd7, 9'd95);
    applyStimulus(3, 4'd9, 4'd3, 9'd123);
    req_valid = 4'b1111;
    seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001, 4'b0010, 4'b0100, 4'b1000};
    for (int g = 0; g < 8; g++) begin
      @(negedge clk);
      checkOutput($sformatf("rr grant %0d", g), 32'(req_ready), 32'(seq[g]));
    end
    tick();
    req_valid = '0;
    repeat (8) tick();

    // Response stall on requester 1 while others keep being served.
    doReset();
    rsp_ready = 4'b1101;
    req_valid = 4'b1111;
    others = 0;
    for (int g = 0; g < 12; g++) begin
      @(negedge clk);
      if (g >= 2) begin
        checkOutput($sformatf("stalled req_ready[1] %0d", g), 32'(req_ready[1]), 32'd0);
        if (req_ready != '0) others++;
      end
    end
    checkOutput("others served", 32'(others >= 4), 32'd1);
    tick();
    req_valid = '0;
    rsp_ready = 4'b1111;
    repeat (8) tick();

    // Fairness: ptr=1 with requesters 0 and 3 eligible grants 3 then 0.
    doReset();
    applyStimulus(0, 4'd4, 4'd4, 9'd68);
    req_valid = 4'b0001;
    tick();
    req_valid = '0;
    repeat (6) tick();
    applyStimulus(3, 4'd6, 4'd1, 9'd77);
    req_valid = 4'b1001;
    @(negedge clk);
    checkOutput("fair first", 32'(req_ready), 32'b1000);
    @(negedge clk);
    checkOutput("fair second", 32'(req_ready), 32'b0001);
    tick();
    req_valid = '0;
    repeat (6) tick();

    // Reset one cycle after accept discards the in-flight op.
    rsp_ready = '0;
    applyStimulus(2, 4'd3, 4'd4, 9'd56);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("mid reset rsp_valid", 32'(rsp_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (6) tick();
    checkOutput("no stale rsp", 32'(rsp_valid), 32'd0);
    rsp_ready = 4'b1111;
    applyStimulus(2, 4'd7, 4'd2, 9'd94);
    req_valid = 4'b0100;
    @(negedge clk);
    checkOutput("fresh grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = '0;
    waitRsp(2, 6);

    for (int n = 0; n < 50 && sb.size() != 0; n++) tick();
    checkOutput("scoreboard drained", 32'(sb.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/calc_rr_arbiter.md
Name: calc_rr_arbiter

Overview:
- Shares one pipelined constant-coefficient datapath, c = 12*a + 5*b (shift-add form: (a<<3)+(a<<2)+(b<<2)+b), among NUM_REQ requesters.
- Round-robin arbitration on the request side; the requester ID travels with the operands through the pipeline.
- Each requester has its own held response register with a valid/ready handshake.
- Sits between requester FSMs and the arithmetic datapath, which is instantiated internally.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must equal ceil(log2(NUM_REQ)).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- req_valid  input  NUM_REQ  per-requester operand request.
- req_a  input  4*NUM_REQ  operand a; requester i uses bits [4i+3:4i].
- req_b  input  4*NUM_REQ  operand b; same packing as req_a.
- req_ready  output  NUM_REQ  one-hot grant; combinational.
- rsp_valid  output  NUM_REQ  result held for requester i.
- rsp_ready  input  NUM_REQ  requester i consumes its result.
- rsp_c  output  9*NUM_REQ  result for requester i, bits [9i+8:9i].

Behaviour:
- Reset (asynchronous, while rst_n low):
  - rsp_valid=0, rsp_c=0, busy=0, pipeline valids=0, rr pointer=0.
  - req_ready forced 0.
  - In-flight operations are discarded, not completed.
- Eligibility: eligible[i] = req_valid[i] & ~busy[i].
  - busy[i] is set on the accept edge.
  - busy[i] is cleared on the edge where rsp_valid[i] & rsp_ready[i].
  - Each requester has at most one outstanding operation.
- Arbitration (combinational):
  - Search eligible requesters starting at index ptr, wrapping modulo NUM_REQ; grant the first found.
  - req_ready is one-hot or zero; it never asserts for a non-eligible requester.
  - Accept = req_valid[i] & req_ready[i].
  - On accept of i: ptr <= (i+1) mod NUM_REQ. With no accept, ptr is unchanged.
- Pipeline, with accept on edge k:
  - Edge k: stage1 captures a, b, id, s1_valid=1.
  - Edge k+1: stage2 registers c = 12a+5b (9-bit, zero-extended; max 255, no overflow), with id and s2_valid.
  - Edge k+2: rsp_c[id] <= c, rsp_valid[id] <= 1.
  - rsp_valid is therefore visible in the cycle after edge k+2, i.e. latency 3 edges.
  - Sustained throughput is 1 accept per cycle across distinct requesters.
- Response side:
  - rsp_c[i] and rsp_valid[i] hold stable until handshake; rsp_ready is ignored while rsp_valid=0.
  - On handshake, rsp_valid[i] <= 0. rsp_c[i] retains its last value; it is not cleared.
  - No collision is possible: busy guarantees a stage2 write never targets a requester whose rsp_valid=1.
- Re-issue by the same requester:
  - Earliest re-accept is in the cycle after its rsp handshake edge.
  - The same requester can be re-granted only once per 4 cycles.
- Simultaneous events:
  - A handshake on requester i and a stage2 write to requester j≠i in the same edge are independent.
  - All requesters eligible: grants cycle ptr, ptr+1, … ; no starvation.
- req_a/req_b are sampled only on the accept edge; changes while not granted are ignored.

Test Plan:
- Reset, then single request: req_valid[2]=1, a=3, b=4 → req_ready[2] high the same cycle; rsp_valid[2] rises 3 edges later with rsp_c[2]=56; held until rsp_ready[2]=1, then drops next edge.
- Max operands: a=15, b=15 on requester 0 → rsp_c[0]=255. Zero operands → 0.
- All four req_valid held high, rsp_ready=1111 from reset → grants 0,1,2,3 on consecutive cycles; requester 0 re-granted no earlier than its rsp handshake +1 cycle. Each result is correct and routed to the right index.
- Response stall: rsp_ready[1]=0 for 10 cycles while req_valid[1] stays high → req_ready[1] stays 0 and rsp_c[1] stays stable. Other requesters continue to be served.
- Fairness: ptr=1, with requesters 0 and 3 both eligible → grant 3, then 0.
- Reset mid-flight: assert rst_n=0 one cycle after accept → all rsp_valid=0 and busy cleared. After release, no stale result appears and a fresh request completes normally.
